// File: rtl/mem_port_arbiter.sv
// Sequencer for the single D-cache port shared by the load unit and the
// committed-store drain; one transaction outstanding at a time.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ld_req_valid,
  input  logic [31:0] ld_req_addr,
  output logic        ld_req_ready,
  output logic        ld_resp_valid,
  output logic [31:0] ld_resp_data,
  input  logic        st_req_valid,
  input  logic [31:0] st_req_addr,
  input  logic [31:0] st_req_data,
  input  logic [1:0]  st_req_size,
  output logic        st_req_ready,
  output logic        dc_req_valid,
  output logic [1:0]  dc_req_cmd,
  output logic [31:0] dc_req_addr,
  output logic [31:0] dc_req_data,
  output logic [1:0]  dc_req_size,
  input  logic        dc_req_ready,
  input  logic        dc_resp_valid,
  input  logic [31:0] dc_resp_data,
  input  logic        squash,
  output logic        port_busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_BUSY = 2'd1,
    ST_BUSY = 2'd2
  } state_t;

  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);

  state_t     state;
  logic [3:0] starve_cnt;
  logic       drop_ld;

  logic ld_ok;
  logic st_win;
  logic ld_win;
  logic arb_en;
  logic ld_grant;
  logic st_grant;

  // Arbitration: only in IDLE, and never while reset is held so that every
  // output reads 0 during reset regardless of the requesters.
  always_comb begin
    ld_ok    = ld_req_valid & ~squash;
    st_win   = st_req_valid & (~ld_ok | (starve_cnt == LIMIT));
    ld_win   = ld_ok & ~st_win;
    arb_en   = (state == IDLE) & ~reset;
    ld_grant = arb_en & ld_win & dc_req_ready;
    st_grant = arb_en & st_win & dc_req_ready;
  end

  always_comb begin
    dc_req_valid = arb_en & (st_win | ld_win);
    dc_req_cmd   = CMD_NONE;
    dc_req_addr  = '0;
    dc_req_data  = '0;
    dc_req_size  = '0;
    if (arb_en & st_win) begin
      dc_req_cmd  = CMD_STORE;
      dc_req_addr = st_req_addr;
      dc_req_data = st_req_data;
      dc_req_size = st_req_size;
    end else if (arb_en & ld_win) begin
      dc_req_cmd  = CMD_LOAD;
      dc_req_addr = ld_req_addr;
      dc_req_size = SIZE_WORD;
    end
  end

  assign ld_req_ready = ld_grant;
  assign st_req_ready = st_grant;
  assign port_busy    = (state != IDLE);

  // Transaction tracking and registered load response.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      starve_cnt    <= '0;
      drop_ld       <= 1'b0;
      ld_resp_valid <= 1'b0;
      ld_resp_data  <= '0;
    end else begin
      ld_resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (st_grant) begin
            state <= ST_BUSY;
          end else if (ld_grant) begin
            state <= LD_BUSY;
          end
          if (!st_req_valid || st_grant) begin
            starve_cnt <= '0;
          end else if (ld_grant && starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 4'd1;
          end
        end
        LD_BUSY: begin
          if (dc_resp_valid) begin
            state   <= IDLE;
            drop_ld <= 1'b0;
            if (!drop_ld && !squash) begin
              ld_resp_valid <= 1'b1;
              ld_resp_data  <= dc_resp_data;
            end
          end else if (squash) begin
            drop_ld <= 1'b1;
          end
        end
        ST_BUSY: begin
          // Committed stores cannot be killed, so squash has no effect here.
          if (dc_resp_valid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected grants and load responses
// are queued as stimulus is driven and retired when the DUT produces them.
module tb_mem_port_arbiter;

  logic        clock;
  logic        reset;
  logic        ld_req_valid;
  logic [31:0] ld_req_addr;
  logic        ld_req_ready;
  logic        ld_resp_valid;
  logic [31:0] ld_resp_data;
  logic        st_req_valid;
  logic [31:0] st_req_addr;
  logic [31:0] st_req_data;
  logic [1:0]  st_req_size;
  logic        st_req_ready;
  logic        dc_req_valid;
  logic [1:0]  dc_req_cmd;
  logic [31:0] dc_req_addr;
  logic [31:0] dc_req_data;
  logic [1:0]  dc_req_size;
  logic        dc_req_ready;
  logic        dc_resp_valid;
  logic [31:0] dc_resp_data;
  logic        squash;
  logic        port_busy;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .ld_req_valid(ld_req_valid), .ld_req_addr(ld_req_addr), .ld_req_ready(ld_req_ready),
    .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
    .st_req_valid(st_req_valid), .st_req_addr(st_req_addr), .st_req_data(st_req_data),
    .st_req_size(st_req_size), .st_req_ready(st_req_ready),
    .dc_req_valid(dc_req_valid), .dc_req_cmd(dc_req_cmd), .dc_req_addr(dc_req_addr),
    .dc_req_data(dc_req_data), .dc_req_size(dc_req_size), .dc_req_ready(dc_req_ready),
    .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
    .squash(squash), .port_busy(port_busy)
  );

  typedef struct {
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } grant_t;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } resp_t;

  grant_t      exp_grant[$];
  resp_t       exp_resp[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          st_pulses = 0;
  int          cache_k = 1;
  logic [31:0] cache_data = '0;
  logic        expect_drop = 1'b0;
  int          t0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_grant(input logic [1:0] cmd, input logic [31:0] addr,
                            input logic [31:0] data, input logic [1:0] size);
    exp_grant.push_back('{cmd: cmd, addr: addr, data: data, size: size});
  endtask

  task automatic wait_grant(input string tag);
    int n = 0;
    @(negedge clock);
    while (!(dc_req_valid && dc_req_ready) && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_seen"}, 64'(dc_req_valid && dc_req_ready), 64'd1);
  endtask

  task automatic monitor_loop();
    grant_t g;
    resp_t  r;
    forever begin
      @(negedge clock);
      if (st_req_ready) st_pulses++;
      if (dc_req_valid && dc_req_ready) begin
        if (exp_grant.size() == 0) begin
          chk("grant_unexpected", 64'(dc_req_valid && dc_req_ready), 64'd0);
        end else begin
          g = exp_grant.pop_front();
          chk("grant_cmd", 64'(dc_req_cmd), 64'(g.cmd));
          chk("grant_addr", 64'(dc_req_addr), 64'(g.addr));
          chk("grant_size", 64'(dc_req_size), 64'(g.size));
          if (g.cmd == 2'd2) chk("grant_data", 64'(dc_req_data), 64'(g.data));
          chk("grant_ld_rdy", 64'(ld_req_ready), 64'(g.cmd == 2'd1));
          chk("grant_st_rdy", 64'(st_req_ready), 64'(g.cmd == 2'd2));
        end
      end else begin
        chk("rdy_without_grant", 64'({ld_req_ready, st_req_ready}), 64'd0);
      end
      if (ld_resp_valid) begin
        if (exp_resp.size() == 0) begin
          chk("ld_resp_unexpected", 64'(ld_resp_valid), 64'd0);
        end else begin
          r = exp_resp.pop_front();
          chk("ld_resp_data", 64'(ld_resp_data), 64'(r.data));
          chk("ld_resp_cycle", 64'(cyc), 64'(r.cyc));
        end
      end else if (exp_resp.size() > 0 && exp_resp[0].cyc < cyc) begin
        r = exp_resp.pop_front();
        chk("ld_resp_missing", 64'(ld_resp_valid), 64'd1);
      end
    end
  endtask

  // Cache model: answers each accepted request cache_k cycles after the grant.
  task automatic cache_loop();
    logic [1:0] c;
    forever begin
      @(negedge clock);
      if (dc_req_valid && dc_req_ready) begin
        c = dc_req_cmd;
        repeat (cache_k) @(posedge clock);
        #1;
        dc_resp_valid = 1'b1;
        dc_resp_data  = cache_data;
        if (c == 2'd1 && !expect_drop) exp_resp.push_back('{data: cache_data, cyc: cyc + 1});
        @(posedge clock);
        #1;
        dc_resp_valid = 1'b0;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    dc_resp_valid = 1'b0;
    dc_resp_data  = '0;
    fork
      monitor_loop();
      cache_loop();
    join_none

    // Reset held with every requester active.
    reset = 1'b1;
    ld_req_valid = 1'b1; ld_req_addr = 32'h100;
    st_req_valid = 1'b1; st_req_addr = 32'h200; st_req_data = 32'h55; st_req_size = 2'd2;
    dc_req_ready = 1'b1; squash = 1'b1;
    tick();
    tick();
    @(negedge clock);
    chk("rst_dc_req_valid", 64'(dc_req_valid), 64'd0);
    chk("rst_dc_req_cmd", 64'(dc_req_cmd), 64'd0);
    chk("rst_ld_req_ready", 64'(ld_req_ready), 64'd0);
    chk("rst_st_req_ready", 64'(st_req_ready), 64'd0);
    chk("rst_ld_resp_valid", 64'(ld_resp_valid), 64'd0);
    chk("rst_ld_resp_data", 64'(ld_resp_data), 64'd0);
    chk("rst_port_busy", 64'(port_busy), 64'd0);

    // Load path, granted in the first cycle after reset, k=3.
    tick();
    reset = 1'b0; st_req_valid = 1'b0; squash = 1'b0;
    cache_k = 3; cache_data = 32'hDEADBEEF;
    t0 = cyc;
    push_grant(2'd1, 32'h100, 32'h0, 2'd2);
    wait_grant("load_grant");
    chk("first_grant_cycle", 64'(cyc), 64'(t0));
    chk("load_ld_req_ready", 64'(ld_req_ready), 64'd1);
    chk("load_cmd", 64'(dc_req_cmd), 64'd1);
    tick();
    ld_req_valid = 1'b0; dc_req_ready = 1'b0;
    @(negedge clock);
    chk("load_busy", 64'(port_busy), 64'd1);
    chk("busy_no_dc_req", 64'(dc_req_valid), 64'd0);
    chk("busy_cmd_none", 64'(dc_req_cmd), 64'd0);
    repeat (4) tick();
    @(negedge clock);
    chk("load_resp_hold", 64'(ld_resp_data), 64'hDEADBEEF);
    chk("load_resp_one_pulse", 64'(ld_resp_valid), 64'd0);

    // Starvation: four loads, then the store, then loads again.
    tick();
    cache_k = 1; cache_data = 32'hC0DE0001;
    ld_req_valid = 1'b1; ld_req_addr = 32'h300;
    st_req_valid = 1'b1; st_req_addr = 32'h200; st_req_data = 32'h55; st_req_size = 2'd2;
    dc_req_ready = 1'b1;
    st_pulses = 0;
    for (int i = 0; i < 4; i++) push_grant(2'd1, 32'h300, 32'h0, 2'd2);
    push_grant(2'd2, 32'h200, 32'h55, 2'd2);
    push_grant(2'd1, 32'h300, 32'h0, 2'd2);
    for (int i = 0; i < 6; i++) begin
      wait_grant("starve_grant");
      if (dc_req_cmd == 2'd2) begin
        tick();
        st_req_valid = 1'b0;
      end
    end
    tick();
    ld_req_valid = 1'b0; dc_req_ready = 1'b0;
    repeat (3) tick();
    @(negedge clock);
    chk("starve_st_pulse_once", 64'(st_pulses), 64'd1);
    chk("starve_idle", 64'(port_busy), 64'd0);

    // Squash after the load grant: response dropped.
    tick();
    cache_k = 2; expect_drop = 1'b1;
    ld_req_valid = 1'b1; ld_req_addr = 32'h400; dc_req_ready = 1'b1;
    push_grant(2'd1, 32'h400, 32'h0, 2'd2);
    wait_grant("squash_grant");
    tick();
    ld_req_valid = 1'b0; dc_req_ready = 1'b0; squash = 1'b1;
    tick();
    squash = 1'b0;
    tick();
    @(negedge clock);
    chk("squash_idle", 64'(port_busy), 64'd0);
    chk("squash_no_resp", 64'(ld_resp_valid), 64'd0);
    tick();
    expect_drop = 1'b0;

    // Squash in the request cycle: load blocked, store granted.
    squash = 1'b1; cache_k = 1;
    ld_req_valid = 1'b1; ld_req_addr = 32'h410;
    st_req_valid = 1'b1; st_req_addr = 32'h500; st_req_data = 32'hAB; st_req_size = 2'd0;
    dc_req_ready = 1'b1;
    push_grant(2'd2, 32'h500, 32'hAB, 2'd0);
    @(negedge clock);
    chk("sq_ld_blocked", 64'(ld_req_ready), 64'd0);
    chk("sq_st_granted", 64'(st_req_ready), 64'd1);
    chk("sq_cmd_store", 64'(dc_req_cmd), 64'd2);
    tick();
    squash = 1'b0; ld_req_valid = 1'b0; st_req_valid = 1'b0; dc_req_ready = 1'b0;
    repeat (2) tick();

    // Backpressure: three cycles without dc_req_ready, grant on the fourth.
    st_req_valid = 1'b1; st_req_addr = 32'h600; st_req_data = 32'h1234; st_req_size = 2'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("bp_no_st_ready", 64'(st_req_ready), 64'd0);
      chk("bp_req_valid", 64'(dc_req_valid), 64'd1);
      chk("bp_addr_stable", 64'(dc_req_addr), 64'h600);
      chk("bp_data_stable", 64'(dc_req_data), 64'h1234);
      chk("bp_idle", 64'(port_busy), 64'd0);
      tick();
    end
    dc_req_ready = 1'b1;
    push_grant(2'd2, 32'h600, 32'h1234, 2'd1);
    @(negedge clock);
    chk("bp_grant_4th", 64'(st_req_ready), 64'd1);
    tick();
    st_req_valid = 1'b0; dc_req_ready = 1'b0;
    repeat (2) tick();

    // Reset while a load is outstanding; the late response is ignored.
    cache_k = 3; expect_drop = 1'b1; cache_data = 32'hBAD0BAD0;
    ld_req_valid = 1'b1; ld_req_addr = 32'h700; dc_req_ready = 1'b1;
    push_grant(2'd1, 32'h700, 32'h0, 2'd2);
    wait_grant("rst_mid_grant");
    tick();
    ld_req_valid = 1'b0; dc_req_ready = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("rst_mid_idle", 64'(port_busy), 64'd0);
    repeat (2) tick();
    @(negedge clock);
    chk("rst_mid_no_resp", 64'(ld_resp_valid), 64'd0);
    chk("rst_mid_still_idle", 64'(port_busy), 64'd0);
    chk("rst_mid_data_cleared", 64'(ld_resp_data), 64'd0);
    tick();
    expect_drop = 1'b0;

    // Recovery: an ordinary load after the mid-operation reset.
    cache_k = 1; cache_data = 32'h13579BDF;
    ld_req_valid = 1'b1; ld_req_addr = 32'h800; dc_req_ready = 1'b1;
    push_grant(2'd1, 32'h800, 32'h0, 2'd2);
    wait_grant("recover_grant");
    tick();
    ld_req_valid = 1'b0; dc_req_ready = 1'b0;
    repeat (4) tick();

    chk("grant_queue_drained", 64'(exp_grant.size()), 64'd0);
    chk("resp_queue_drained", 64'(exp_resp.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
